// File: rtl/seq_contador_arb.sv
// Two-requester round-robin sequencer that drives an external up/down counter
// through clear/step bursts. Optional wrap detection: define SEQ_WRAP_DETECT_EN.
module seq_contador_arb #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clkk,
  input  logic              rstt,
  input  logic              req0_valid,
  input  logic              req0_dir,
  input  logic              req0_clr,
  input  logic [STEP_W-1:0] req0_steps,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_dir,
  input  logic              req1_clr,
  input  logic [STEP_W-1:0] req1_steps,
  output logic              req1_ready,
  output logic              cnt_en,
  output logic              cnt_ud,
  output logic              cnt_clr,
  input  logic [WIDTH-1:0]  cnt_val,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [WIDTH-1:0]  result,
  output logic              wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                last_r;
  logic                id_r;
  logic                dir_r;
  logic [STEP_W-1:0]   rem_r;
  logic [WIDTH-1:0]    result_r;

  logic                any_s;
  logic                win_s;
  logic                hs_s;
  logic                sel_dir_s;
  logic                sel_clr_s;
  logic [STEP_W-1:0]   sel_steps_s;

  // Round-robin winner: on a tie the requester not granted last time wins
  always_comb begin
    any_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_s = ~last_r;
    end else begin
      win_s = req1_valid;
    end
    if (win_s) begin
      sel_dir_s   = req1_dir;
      sel_clr_s   = req1_clr;
      sel_steps_s = req1_steps;
    end else begin
      sel_dir_s   = req0_dir;
      sel_clr_s   = req0_clr;
      sel_steps_s = req0_steps;
    end
    hs_s = (state_r == IDLE) & any_s;
  end

  // Ready is gated by reset so no strobe escapes while the block is held
  assign req0_ready = hs_s & ~win_s & rstt;
  assign req1_ready = hs_s &  win_s & rstt;

  // State register
  always_ff @(posedge clkk or negedge rstt) begin
    if (!rstt) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          if (sel_clr_s) begin
            state_s = CLEAR;
          end else if (sel_steps_s != '0) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (rem_r != '0) begin
          state_s = RUN;
        end else begin
          state_s = DONE;
        end
      end
      RUN: begin
        if (rem_r <= STEP_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Burst context: latched at the handshake, step budget burned down in RUN
  always_ff @(posedge clkk or negedge rstt) begin
    if (!rstt) begin
      last_r <= 1'b1;
      id_r   <= 1'b0;
      dir_r  <= 1'b0;
      rem_r  <= '0;
    end else if (hs_s) begin
      last_r <= win_s;
      id_r   <= win_s;
      dir_r  <= sel_dir_s;
      rem_r  <= sel_steps_s;
    end else if (state_r == RUN) begin
      rem_r  <= rem_r - STEP_W'(1);
    end else begin
      rem_r  <= rem_r;
    end
  end

  // Completion capture; the counter has settled by the DONE cycle
  always_ff @(posedge clkk or negedge rstt) begin
    if (!rstt) begin
      result_r <= '0;
    end else if (state_r == DONE) begin
      result_r <= cnt_val;
    end else begin
      result_r <= result_r;
    end
  end

  // Output decode from the registered state
  always_comb begin
    busy    = 1'b0;
    cnt_en  = 1'b0;
    cnt_ud  = 1'b0;
    cnt_clr = 1'b0;
    done    = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      CLEAR: begin
        busy    = 1'b1;
        cnt_clr = 1'b1;
      end
      RUN: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        cnt_ud = dir_r;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign done_id = id_r;
  assign result  = (state_r == DONE) ? cnt_val : result_r;

`ifdef SEQ_WRAP_DETECT_EN
  logic wflag_r;
  logic wrap_r;
  logic at_edge_s;

  assign at_edge_s = (dir_r  && (cnt_val == {WIDTH{1'b1}})) ||
                     (!dir_r && (cnt_val == {WIDTH{1'b0}}));

  // Sticky boundary flag for the current burst
  always_ff @(posedge clkk or negedge rstt) begin
    if (!rstt) begin
      wflag_r <= 1'b0;
    end else if (hs_s) begin
      wflag_r <= 1'b0;
    end else if ((state_r == RUN) && at_edge_s) begin
      wflag_r <= 1'b1;
    end else begin
      wflag_r <= wflag_r;
    end
  end

  // Held copy of the flag, updated alongside result
  always_ff @(posedge clkk or negedge rstt) begin
    if (!rstt) begin
      wrap_r <= 1'b0;
    end else if (state_r == DONE) begin
      wrap_r <= wflag_r;
    end else begin
      wrap_r <= wrap_r;
    end
  end

  assign wrap = (state_r == DONE) ? wflag_r : wrap_r;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_seq_contador_arb.sv
// Randomized bench for seq_contador_arb with a burst-level reference model
// and a behavioural 8-bit counter standing in for the real datapath.
module tb_seq_contador_arb;

  logic       clkk = 1'b0;
  logic       rstt;
  logic       req0_valid, req0_dir, req0_clr, req0_ready;
  logic [7:0] req0_steps;
  logic       req1_valid, req1_dir, req1_clr, req1_ready;
  logic [7:0] req1_steps;
  logic       cnt_en, cnt_ud, cnt_clr, busy, done, done_id, wrap;
  logic [7:0] result;
  logic [7:0] cnt = 8'd0;

  seq_contador_arb #(.WIDTH(8), .STEP_W(8)) dut (
    .clkk(clkk), .rstt(rstt),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_clr(req0_clr),
    .req0_steps(req0_steps), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_clr(req1_clr),
    .req1_steps(req1_steps), .req1_ready(req1_ready),
    .cnt_en(cnt_en), .cnt_ud(cnt_ud), .cnt_clr(cnt_clr), .cnt_val(cnt),
    .busy(busy), .done(done), .done_id(done_id), .result(result), .wrap(wrap)
  );

  always #5 clkk = ~clkk;

  // Stand-in counter: wraps modulo 256
  always_ff @(posedge clkk) begin
    if (cnt_clr) cnt <= 8'd0;
    else if (cnt_en) cnt <= cnt_ud ? cnt + 8'd1 : cnt - 8'd1;
    else cnt <= cnt;
  end

  typedef struct packed {
    bit busy; bit en; bit ud; bit clr; bit done; bit id; bit wr;
    logic [7:0] res;
  } exp_t;

  exp_t       sched[$];
  bit         last;
  logic [7:0] held_res;
  bit         held_wrap;
  int         nvec, nerr, cyc, hs_cyc;
  int         done_cycs[$];
  int         done_ids[$];
  logic [7:0] pin_res;
  bit         pin_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expand an accepted burst into its cycle-by-cycle expected outputs
  task automatic build(input bit id, input bit d, input bit c, input logic [7:0] n);
    exp_t e;
    logic [7:0] start, v;
    bit wr;
    wr = 1'b0;
    start = c ? 8'd0 : cnt;
    if (c) begin
      e = '0; e.busy = 1'b1; e.clr = 1'b1; sched.push_back(e);
    end
    for (int k = 0; k < int'(n); k++) begin
      v = d ? start + 8'(k) : start - 8'(k);
      if ((d && v == 8'hFF) || (!d && v == 8'h00)) wr = 1'b1;
      e = '0; e.busy = 1'b1; e.en = 1'b1; e.ud = d; sched.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.id = id; e.wr = wr;
    e.res = d ? start + n : start - n;
    sched.push_back(e);
  endtask

  // One clock: predict, compare at negedge, retire accepted requests after posedge
  task automatic cycle();
    exp_t e;
    bit g, r0, r1;
    @(negedge clkk);
    cyc++;
    r0 = 1'b0; r1 = 1'b0; e = '0;
    if (sched.size() != 0) begin
      e = sched.pop_front();
    end else if (req0_valid || req1_valid) begin
      g = (req0_valid && req1_valid) ? !last : req1_valid;
      last = g; r0 = !g; r1 = g; hs_cyc = cyc;
      if (g) build(1'b1, req1_dir, req1_clr, req1_steps);
      else   build(1'b0, req0_dir, req0_clr, req0_steps);
    end
    if (e.done) begin
      held_res = e.res; held_wrap = e.wr;
      done_cycs.push_back(cyc); done_ids.push_back(int'(done_id));
      pin_res = result; pin_wrap = wrap;
    end
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    chk("busy", busy, e.busy);
    chk("cnt_en", cnt_en, e.en);
    chk("cnt_clr", cnt_clr, e.clr);
    chk("done", done, e.done);
    if (e.en || !e.busy) chk("cnt_ud", cnt_ud, e.ud);
    if (e.done) chk("done_id", done_id, e.id);
    chk("result", result, held_res);
`ifdef SEQ_WRAP_DETECT_EN
    chk("wrap", wrap, held_wrap);
`else
    chk("wrap", wrap, 1'b0);
`endif
    @(posedge clkk); #1;
    if (r0) req0_valid = 1'b0;
    if (r1) req1_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((sched.size() != 0 || req0_valid || req1_valid) && n < maxc) begin
      cycle(); n++;
    end
    if (n >= maxc) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout after %0d cycles, required idle", n);
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop without a clock edge
  task automatic do_reset();
    rstt = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_cnt_clr", cnt_clr, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'd0);
    chk("rst_wrap", wrap, 1'b0);
    sched.delete(); last = 1'b1; held_res = 8'd0; held_wrap = 1'b0;
    @(posedge clkk); #1;
    rstt = 1'b1;
  endtask

  task automatic req(input bit r, input bit d, input bit c, input logic [7:0] n);
    if (r) begin req1_valid = 1'b1; req1_dir = d; req1_clr = c; req1_steps = n; end
    else   begin req0_valid = 1'b1; req0_dir = d; req0_clr = c; req0_steps = n; end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; hs_cyc = 0;
    last = 1'b1; held_res = 8'd0; held_wrap = 1'b0;
    rstt = 1'b0;
    req0_valid = 1'b0; req0_dir = 1'b0; req0_clr = 1'b0; req0_steps = 8'd0;
    req1_valid = 1'b0; req1_dir = 1'b0; req1_clr = 1'b0; req1_steps = 8'd0;
    repeat (2) @(posedge clkk);
    #1;
    req0_valid = 1'b1; #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_result0", result, 8'd0);
    req0_valid = 1'b0;
    @(posedge clkk); #1;
    rstt = 1'b1;

    // Single up burst from 0
    req(1'b0, 1'b1, 1'b0, 8'd4); drain(50);
    chk("t1_result", pin_res, 8'd4);
    chk("t1_latency", done_cycs[done_cycs.size()-1] - hs_cyc, 5);
    chk("t1_id", done_ids[done_ids.size()-1], 0);

    // Clear then two down steps: 0 -> 255 -> 254
    req(1'b0, 1'b0, 1'b1, 8'd2); drain(50);
    chk("t2_result", pin_res, 8'd254);
    chk("t2_latency", done_cycs[done_cycs.size()-1] - hs_cyc, 4);
`ifdef SEQ_WRAP_DETECT_EN
    chk("t2_wrap", pin_wrap, 1'b1);
`endif

    // Simultaneous requests after reset alternate 0,1,0,1
    do_reset();
    done_ids.delete();
    req(1'b0, 1'b1, 1'b0, 8'd1); req(1'b1, 1'b1, 1'b0, 8'd1); drain(50);
    req(1'b0, 1'b1, 1'b0, 8'd1); req(1'b1, 1'b1, 1'b0, 8'd1); drain(50);
    chk("t3_count", done_ids.size(), 4);
    for (int i = 0; i < 4 && i < done_ids.size(); i++) chk("t3_order", done_ids[i], i % 2);

    // Set counter to 7, then a zero-step burst must echo it
    req(1'b0, 1'b1, 1'b1, 8'd7); drain(50);
    chk("t4_setup", pin_res, 8'd7);
    req(1'b1, 1'b0, 1'b0, 8'd0); drain(50);
    chk("t4_result", pin_res, 8'd7);
    chk("t4_latency", done_cycs[done_cycs.size()-1] - hs_cyc, 1);

    // Request while busy waits for the idle cycle after DONE
    req(1'b0, 1'b1, 1'b0, 8'd10);
    repeat (3) cycle();
    req(1'b1, 1'b1, 1'b0, 8'd1); drain(60);
    chk("t5_gap", hs_cyc - done_cycs[done_cycs.size()-2], 1);
    chk("t5_result", pin_res, 8'd18);
    chk("t5_id", done_ids[done_ids.size()-1], 1);

    // Reset mid-RUN abandons the burst
    req(1'b0, 1'b1, 1'b0, 8'd10);
    repeat (4) cycle();
    do_reset();
    repeat (5) cycle();
    req(1'b1, 1'b0, 1'b0, 8'd2); drain(50);
    chk("t6_id", done_ids[done_ids.size()-1], 1);

    // Random traffic
    for (int it = 0; it < 2500; it++) begin
      if (!req0_valid && $urandom_range(0, 3) == 0)
        req(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9)));
      if (!req1_valid && $urandom_range(0, 3) == 0)
        req(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9)));
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    drain(1200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_contador_arb.md
Name: seq_contador_arb

Overview:
- Two-requester sequencer and arbiter for the team's 8-bit up/down counter datapath.
- Accepts count bursts (direction, step count, optional clear) from two requesters.
- Grants one burst at a time using round-robin arbitration.
- Drives the counter's enable, direction and clear lines, then returns the final count with a done pulse.
- Sits between control logic and the counter; the counter itself stays a separate module.

Parameters:
WIDTH, 8, counter width (cnt_val, result)
STEP_W, 8, width of the burst step-count field

Ports:
clkk  in  1  clock, rising edge
rstt  in  1  reset, asynchronous, active-low
req0_valid  in  1  requester 0 burst request
req0_dir  in  1  requester 0 direction, 1=up 0=down
req0_clr  in  1  requester 0: clear counter before burst
req0_steps  in  STEP_W  requester 0 number of count steps
req0_ready  out  1  requester 0 accept strobe
req1_valid, req1_dir, req1_clr, req1_steps, req1_ready  same as requester 0, for requester 1
cnt_en  out  1  counter step enable; counter steps on clkk edge while 1
cnt_ud  out  1  counter direction, 1=up
cnt_clr  out  1  synchronous counter clear
cnt_val  in  WIDTH  current counter value
busy  out  1  burst in progress
done  out  1  one-cycle completion pulse
done_id  out  1  requester index of completed burst
result  out  WIDTH  cnt_val captured at completion
wrap  out  1  wrap indicator (see Optional Feature)

Behaviour:
- Reset (rstt=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer is set so requester 0 wins the first tie.
  - Reset mid-burst abandons the burst; no done is generated.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - With no valid request: busy=0, all cnt_* outputs = 0.
  - With any valid request, the winner is chosen combinationally and its ready=1 for that cycle only. A handshake is valid&&ready.
  - On the handshake, latch dir, clr, steps and id.
  - Next state: CLEAR if clr=1; else RUN if steps!=0; else DONE.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins; the pointer updates on every grant.
  - The loser keeps valid high and is served next.
- Requester rules:
  - Requests are never accepted outside IDLE; ready=0 whenever busy=1.
  - A requester must hold valid and its fields stable until ready.
  - Fields are sampled only in the handshake cycle.
- CLEAR: cnt_clr=1 for exactly 1 cycle. Next state is RUN if steps!=0, else DONE.
- RUN:
  - cnt_en=1 and cnt_ud=latched dir for exactly `steps` consecutive cycles.
  - An internal remaining-step counter is loaded with steps and decremented each cycle; leave RUN when it reaches 1.
- DONE:
  - done=1 for 1 cycle; done_id=latched id; result=cnt_val is registered and held until the next DONE.
  - Next state is IDLE. A new handshake is possible in the cycle after DONE, giving a back-to-back throughput gap of 1 idle cycle.
- busy=1 in CLEAR, RUN and DONE.
- Latency, with the handshake at cycle T:
  - done asserts at cycle T+steps+1, plus 1 if clr=1.
  - steps=0 with clr=0: done at T+1, result = unchanged counter value.
- Counter arithmetic:
  - The counter wraps modulo 2^WIDTH; the sequencer never saturates or stops at a boundary.
  - steps is unsigned; the maximum burst is 2^STEP_W−1 steps.

Optional Feature:
- Macro: SEQ_WRAP_DETECT_EN.
- Defined:
  - An internal flag clears at each handshake.
  - It sets in any RUN cycle where (cnt_ud=1 and cnt_val=all-ones) or (cnt_ud=0 and cnt_val=0).
  - In DONE, wrap equals the flag and is held with result.
- Undefined: the wrap port is tied to 0 and no detection logic is built.

Test Plan:
- Single up burst, counter at 0: req0 valid, dir=1, clr=0, steps=4 → ready at T, cnt_en high 4 cycles, done at T+5, result=4, done_id=0.
- Clear then down: counter=4; req0 dir=0, clr=1, steps=2 → cnt_clr 1 cycle, 2 enable cycles, result=254 (0xFE); with SEQ_WRAP_DETECT_EN, wrap=1.
- Simultaneous requests after reset: req0 and req1 both valid with steps=1 → req0 granted first, req1 granted in the IDLE cycle after req0's DONE; done_id sequence 0 then 1. Repeat both → order 0,1 again by round-robin alternation.
- Zero-step burst: req1 steps=0, clr=0, counter=7 → done at T+1, result=7, cnt_en never asserted.
- Request during busy: req1 raised while req0 is running steps=10 → req1_ready stays 0 until req0's DONE, then accepted.
- Reset mid-RUN: rstt low during a 10-step burst → busy, cnt_en, done, result all drop to 0 immediately; no done pulse afterward; the next request is accepted normally.
